simple_bus_arbiter: RTL

- Shares one memory port between the VexRiscv instruction bus (iBus) and data bus (dBus), both in the simple cmd/rsp bus format.
- Command path:
  - Fixed dBus priority with a starvation guard for iBus.
  - Grant lock while a presented command is stalled.
  - Byte-mask generation from dBus size and address.
- Response path: read responses are routed back through an in-order source-tag FIFO.
- Sits between the core and the single-ported memory model or SoC interconnect in formal and simulation top levels.

---
 rtl/simple_bus_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/simple_bus_arbiter.sv
// rtl/simple_bus_arbiter.sv - shares one memory port between the VexRiscv iBus and dBus
// dBus-priority grant with iBus starvation guard, stall lock and in-order read tag FIFO.
module simple_bus_arbiter #(
  parameter int MAX_PENDING  = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           ibus_cmd_valid,
  output logic                           ibus_cmd_ready,
  input  logic [31:0]                    ibus_cmd_pc,
  output logic                           ibus_rsp_valid,
  output logic [31:0]                    ibus_rsp_inst,
  input  logic                           dbus_cmd_valid,
  output logic                           dbus_cmd_ready,
  input  logic                           dbus_cmd_wr,
  input  logic [31:0]                    dbus_cmd_address,
  input  logic [31:0]                    dbus_cmd_data,
  input  logic [1:0]                     dbus_cmd_size,
  output logic                           dbus_rsp_valid,
  output logic [31:0]                    dbus_rsp_data,
  output logic                           mem_cmd_valid,
  input  logic                           mem_cmd_ready,
  output logic                           mem_cmd_wr,
  output logic [31:0]                    mem_cmd_addr,
  output logic [31:0]                    mem_cmd_data,
  output logic [3:0]                     mem_cmd_mask,
  input  logic                           mem_rsp_valid,
  input  logic [31:0]                    mem_rsp_data,
  output logic [$clog2(MAX_PENDING):0]   pending_count,
  output logic                           rsp_orphan
);

  localparam int CW = $clog2(MAX_PENDING) + 1;
  localparam int PW = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 2);

  typedef enum logic [1:0] {IDLE, LOCK_I, LOCK_D} state_e;

  state_e                 state_q, state_d;
  logic [SW-1:0]          starve_q, starve_d;
  logic [MAX_PENDING-1:0] tags_q, tags_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   orphan_q, orphan_d;

  logic       fifo_empty, fifo_full, pop, push, read_block;
  logic       ibus_pres, dbus_pres, starved, sel_d, presented, accept, head;
  logic [1:0] eff_size;
  logic [3:0] base_mask, dmask;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(MAX_PENDING - 1)) return '0;
    return p + PW'(1);
  endfunction

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(MAX_PENDING));
  assign pop        = !reset && mem_rsp_valid && !fifo_empty;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts a read then.
  assign read_block = fifo_full && !pop;
  assign ibus_pres  = ibus_cmd_valid && !read_block;
  assign dbus_pres  = dbus_cmd_valid && (dbus_cmd_wr || !read_block);
  assign starved    = ibus_cmd_valid && (starve_q == SW'(STARVE_LIMIT));

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:           if (mem_cmd_valid && !mem_cmd_ready) state_d = sel_d ? LOCK_D : LOCK_I;
      LOCK_I, LOCK_D: if (mem_cmd_ready) state_d = IDLE;
      default:        state_d = IDLE;
    endcase
  end

  always_comb begin
    sel_d = 1'b0;
    case (state_q)
      LOCK_I:  sel_d = 1'b0;
      LOCK_D:  sel_d = 1'b1;
      default: sel_d = dbus_pres && !(starved && ibus_pres);
    endcase
  end

  assign eff_size  = (dbus_cmd_size == 2'd3) ? 2'd2 : dbus_cmd_size;
  assign base_mask = (eff_size == 2'd0) ? 4'b0001 : (eff_size == 2'd1) ? 4'b0011 : 4'b1111;
  assign dmask     = base_mask << dbus_cmd_address[1:0];

  assign presented      = sel_d ? dbus_pres : ibus_pres;
  assign mem_cmd_valid  = !reset && presented;
  assign accept         = mem_cmd_valid && mem_cmd_ready;
  assign ibus_cmd_ready = accept && !sel_d;
  assign dbus_cmd_ready = accept && sel_d;
  assign push           = accept && (!sel_d || !dbus_cmd_wr);

  assign mem_cmd_wr   = sel_d && dbus_cmd_wr;
  assign mem_cmd_addr = sel_d ? dbus_cmd_address : ibus_cmd_pc;
  assign mem_cmd_data = sel_d ? dbus_cmd_data : 32'h0;
  assign mem_cmd_mask = sel_d ? dmask : 4'b1111;

  assign head           = tags_q[rd_ptr_q];
  assign ibus_rsp_valid = pop && !head;
  assign dbus_rsp_valid = pop && head;
  assign ibus_rsp_inst  = mem_rsp_data;
  assign dbus_rsp_data  = mem_rsp_data;
  assign pending_count  = count_q;
  assign rsp_orphan     = orphan_q;

  always_comb begin
    starve_d = starve_q;
    if (!ibus_cmd_valid || ibus_cmd_ready)
      starve_d = '0;
    else if (dbus_cmd_ready && starve_q != SW'(STARVE_LIMIT))
      starve_d = starve_q + SW'(1);
  end

  always_comb begin
    tags_d   = tags_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      tags_d[wr_ptr_q] = sel_d;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    count_d  = count_q + CW'(push) - CW'(pop);
    orphan_d = orphan_q || (mem_rsp_valid && fifo_empty);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
      tags_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      orphan_q <= 1'b0;
    end else begin
      starve_q <= starve_d;
      tags_q   <= tags_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      orphan_q <= orphan_d;
    end
  end

endmodule
